// File: rtl/camera_pkg.sv
// Shared types for the camera windowing slice.
// Frame-sync FSM states and decimation encodings.
package camera_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        ARMED     = 2'd1,
        ACTIVE    = 2'd2
    } fsm_state_t;

    typedef enum logic [1:0] {
        DECIM_1X     = 2'd0,
        DECIM_2X     = 2'd1,
        DECIM_4X     = 2'd2,
        DECIM_4X_ALT = 2'd3
    } decim_t;

    function automatic logic [1:0] decim_shift(input logic [1:0] d);
        logic [1:0] s;
        unique case (decim_t'(d))
            DECIM_1X: s = 2'd0;
            DECIM_2X: s = 2'd1;
            default:  s = 2'd2;
        endcase
        return s;
    endfunction

    function automatic logic [1:0] decim_mask(input logic [1:0] d);
        logic [1:0] m;
        unique case (decim_t'(d))
            DECIM_1X: m = 2'b00;
            DECIM_2X: m = 2'b01;
            default:  m = 2'b11;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/camera_frame_sync.sv
// Frame-sync FSM, raw column/line counters and frame status.
// Counters saturate at the geometry limits; errors are sticky per frame.
module camera_frame_sync
    import camera_pkg::*;
#(
    parameter  int MAX_W = 752,
    parameter  int MAX_H = 480,
    localparam int CW    = $clog2(MAX_W),
    localparam int LW    = $clog2(MAX_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fv,
    input  logic          lv,
    input  logic          enable,
    output logic          start,
    output logic          pix,
    output logic [CW:0]   col,
    output logic [LW:0]   line,
    output logic          frame_end,
    output logic [15:0]   frame_count,
    output logic          len_err,
    output logic          ovf_err
);

    localparam logic [CW:0] COL_MAX = (CW+1)'(MAX_W);
    localparam logic [LW:0] LINE_MAX = (LW+1)'(MAX_H);

    fsm_state_t state, state_nxt;
    logic active;
    logic lv_d;
    logic run, accept, line_end, fend;
    logic col_sat, line_sat;
    logic have_len;
    logic [CW:0] first_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_IDLE: if (!fv)          state_nxt = ARMED;
            ARMED:     if (fv && enable) state_nxt = ACTIVE;
            ACTIVE:    if (!fv)          state_nxt = ARMED;
            default:                     state_nxt = WAIT_IDLE;
        endcase
    end

    always_comb begin
        start  = (state == ARMED) && fv && enable;
        active = (state == ACTIVE);
    end

    // The frame-start cycle already carries a pixel when LINE_VALID is high.
    assign run      = (active || start) && fv;
    assign accept   = run && lv;
    assign col_sat  = (col == COL_MAX);
    assign line_sat = (line == LINE_MAX);
    assign pix      = accept && !col_sat && !line_sat;
    assign line_end = active && lv_d && !lv;
    assign fend     = active && !fv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lv_d <= 1'b0;
            col  <= '0;
            line <= '0;
        end else begin
            lv_d <= lv;
            if (!run) begin
                col  <= '0;
                line <= '0;
            end else begin
                if (!lv)          col <= '0;
                else if (!col_sat) col <= col + 1'b1;
                if (line_end && !line_sat) line <= line + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_len    <= 1'b0;
            first_len   <= '0;
            len_err     <= 1'b0;
            ovf_err     <= 1'b0;
            frame_end   <= 1'b0;
            frame_count <= '0;
        end else begin
            if (start) begin
                have_len <= 1'b0;
                len_err  <= 1'b0;
                ovf_err  <= 1'b0;
            end else begin
                if (line_end) begin
                    if (!have_len) begin
                        first_len <= col;
                        have_len  <= 1'b1;
                    end else if (col != first_len) begin
                        len_err <= 1'b1;
                    end
                end
                if (accept && (col_sat || line_sat)) ovf_err <= 1'b1;
            end
            frame_end <= fend;
            if (fend) frame_count <= frame_count + 1'b1;
        end
    end

endmodule

// File: rtl/camera_window.sv
// Region-of-interest windowing and decimation of a parallel sensor stream.
// Window geometry is frozen at frame start; output is registered (latency 1).
module camera_window
    import camera_pkg::*;
#(
    parameter  int DATA_W = 10,
    parameter  int MAX_W  = 752,
    parameter  int MAX_H  = 480,
    localparam int CW     = $clog2(MAX_W),
    localparam int LW     = $clog2(MAX_H)
) (
    input  logic              PIXCLK,
    input  logic              RESET_N,
    input  logic              FRAME_VALID,
    input  logic              LINE_VALID,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              ENABLE,
    input  logic [CW-1:0]     ROI_X0,
    input  logic [LW-1:0]     ROI_Y0,
    input  logic [CW:0]       ROI_W,
    input  logic [LW:0]       ROI_H,
    input  logic [1:0]        DECIM,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic [CW-1:0]     CURRENT_COLUMN,
    output logic [LW-1:0]     CURRENT_LINE,
    output logic              PIXEL_VALID,
    output logic              FRAME_START,
    output logic              FRAME_END,
    output logic [15:0]       FRAME_COUNT,
    output logic              LINE_LEN_ERR,
    output logic              OVERFLOW_ERR
);

    logic          start, pix, first_done, emit;
    logic [CW:0]   col, rel_x, w_q, w_e;
    logic [LW:0]   line, rel_y, h_q, h_e;
    logic [CW-1:0] x0_q, x0_e;
    logic [LW-1:0] y0_q, y0_e;
    logic [1:0]    dec_q, dec_e, sh, mask;
    logic          in_x, in_y, dec_ok;

    camera_frame_sync #(
        .MAX_W(MAX_W),
        .MAX_H(MAX_H)
    ) u_sync (
        .clk        (PIXCLK),
        .rst_n      (RESET_N),
        .fv         (FRAME_VALID),
        .lv         (LINE_VALID),
        .enable     (ENABLE),
        .start      (start),
        .pix        (pix),
        .col        (col),
        .line       (line),
        .frame_end  (FRAME_END),
        .frame_count(FRAME_COUNT),
        .len_err    (LINE_LEN_ERR),
        .ovf_err    (OVERFLOW_ERR)
    );

    always_ff @(posedge PIXCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            x0_q  <= '0;
            y0_q  <= '0;
            w_q   <= '0;
            h_q   <= '0;
            dec_q <= '0;
        end else if (start) begin
            x0_q  <= ROI_X0;
            y0_q  <= ROI_Y0;
            w_q   <= ROI_W;
            h_q   <= ROI_H;
            dec_q <= DECIM;
        end
    end

    // The start cycle may already hold a pixel, so it sees the live geometry.
    always_comb begin
        x0_e  = start ? ROI_X0 : x0_q;
        y0_e  = start ? ROI_Y0 : y0_q;
        w_e   = start ? ROI_W  : w_q;
        h_e   = start ? ROI_H  : h_q;
        dec_e = start ? DECIM  : dec_q;
    end

    always_comb begin
        rel_x  = col - {1'b0, x0_e};
        rel_y  = line - {1'b0, y0_e};
        in_x   = (col >= {1'b0, x0_e}) && (rel_x < w_e);
        in_y   = (line >= {1'b0, y0_e}) && (rel_y < h_e);
        sh     = decim_shift(dec_e);
        mask   = decim_mask(dec_e);
        dec_ok = ((rel_x[1:0] & mask) == 2'b00) &&
                 ((rel_y[1:0] & mask) == 2'b00);
        emit   = pix && in_x && in_y && dec_ok;
    end

    always_ff @(posedge PIXCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            DATA_OUT       <= '0;
            CURRENT_COLUMN <= '0;
            CURRENT_LINE   <= '0;
            PIXEL_VALID    <= 1'b0;
            FRAME_START    <= 1'b0;
            first_done     <= 1'b0;
        end else begin
            PIXEL_VALID <= emit;
            FRAME_START <= emit && (start || !first_done);
            if (start)     first_done <= emit;
            else if (emit) first_done <= 1'b1;
            if (emit) begin
                DATA_OUT       <= DATA_IN;
                CURRENT_COLUMN <= CW'(rel_x >> sh);
                CURRENT_LINE   <= LW'(rel_y >> sh);
            end
        end
    end

endmodule

// File: tb/tb_camera_window.sv
// Directed self-checking bench for camera_window on a 4x4 sensor.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
module tb_camera_window;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fv, lv, en;
    logic [9:0] din;
    logic [1:0] x0, y0, dec;
    logic [2:0] w, h;
    logic [9:0] dout;
    logic [1:0] ccol, cline;
    logic       pv, fs, fe, lle, ovf;
    logic [15:0] fc;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    camera_window #(
        .DATA_W(10),
        .MAX_W (4),
        .MAX_H (4)
    ) dut (
        .PIXCLK        (clk),
        .RESET_N       (rst_n),
        .FRAME_VALID   (fv),
        .LINE_VALID    (lv),
        .DATA_IN       (din),
        .ENABLE        (en),
        .ROI_X0        (x0),
        .ROI_Y0        (y0),
        .ROI_W         (w),
        .ROI_H         (h),
        .DECIM         (dec),
        .DATA_OUT      (dout),
        .CURRENT_COLUMN(ccol),
        .CURRENT_LINE  (cline),
        .PIXEL_VALID   (pv),
        .FRAME_START   (fs),
        .FRAME_END     (fe),
        .FRAME_COUNT   (fc),
        .LINE_LEN_ERR  (lle),
        .OVERFLOW_ERR  (ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 64'({pv, fs, fe, lle, ovf, fc, dout, ccol, cline}), 64'd0);
    endtask

    task automatic chk_pix(input string tag, input logic f, input logic [9:0] d,
                           input logic [1:0] c, input logic [1:0] l);
        check(tag, 64'({pv, fs, dout, ccol, cline}), 64'({1'b1, f, d, c, l}));
    endtask

    task automatic cyc(input logic f, input logic l, input logic [9:0] d);
        @(negedge clk);
        fv  = f;
        lv  = l;
        din = d;
        @(posedge clk);
        #1;
    endtask

    // 4x4 frame, pixel value 100+10*line+col; mask bit line*4+col marks emits.
    task automatic frame4(input string tag, input logic [15:0] mask,
                          input int ex0, input int ey0, input int sh,
                          input bit poke);
        bit first = 1'b1;
        for (int l = 0; l < 4; l++) begin
            for (int c = 0; c < 4; c++) begin
                cyc(1'b1, 1'b1, 10'(100 + 10 * l + c));
                if (mask[l * 4 + c]) begin
                    chk_pix(tag, first, 10'(100 + 10 * l + c),
                            2'((c - ex0) >> sh), 2'((l - ey0) >> sh));
                    first = 1'b0;
                end else begin
                    check({tag, "_idle"}, 64'(pv), 64'd0);
                end
            end
            cyc(1'b1, 1'b0, 10'd0);
            if (poke && l == 0) begin
                x0  = 2'd3;
                dec = 2'd2;
            end
        end
        cyc(1'b0, 1'b0, 10'd0);
        check({tag, "_fend"}, 64'(fe), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        fv = 1'b1;
        lv = 1'b1;
        en = 1'b1;
        din = 10'd7;
        x0 = 2'd0;
        y0 = 2'd0;
        w = 3'd4;
        h = 3'd4;
        dec = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");

        // Frame already running at reset release must be skipped.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 10'd7);
            check("inprog_drop", 64'(pv), 64'd0);
        end
        cyc(1'b0, 1'b0, 10'd0);
        check("arm_idle", 64'(pv), 64'd0);

        cyc(1'b1, 1'b1, 10'd11);
        chk_pix("f1_p11", 1'b1, 10'd11, 2'd0, 2'd0);
        cyc(1'b1, 1'b1, 10'd12);
        chk_pix("f1_p12", 1'b0, 10'd12, 2'd1, 2'd0);
        cyc(1'b1, 1'b0, 10'd0);
        check("f1_hold", 64'({pv, dout, ccol, cline}),
              64'({1'b0, 10'd12, 2'd1, 2'd0}));
        cyc(1'b1, 1'b1, 10'd21);
        chk_pix("f1_p21", 1'b0, 10'd21, 2'd0, 2'd1);
        cyc(1'b1, 1'b1, 10'd22);
        chk_pix("f1_p22", 1'b0, 10'd22, 2'd1, 2'd1);
        cyc(1'b1, 1'b0, 10'd0);
        cyc(1'b1, 1'b1, 10'd31);
        chk_pix("f1_p31", 1'b0, 10'd31, 2'd0, 2'd2);
        cyc(1'b1, 1'b1, 10'd32);
        chk_pix("f1_p32", 1'b0, 10'd32, 2'd1, 2'd2);
        cyc(1'b1, 1'b0, 10'd0);
        check("f1_no_fend", 64'(fe), 64'd0);
        cyc(1'b0, 1'b0, 10'd0);
        check("f1_fend", 64'({fe, fc}), 64'({1'b1, 16'd1}));
        cyc(1'b0, 1'b0, 10'd0);
        check("f1_fend_once", 64'({fe, fc, lle}), 64'({1'b0, 16'd1, 1'b0}));

        x0 = 2'd1;
        y0 = 2'd1;
        w = 3'd2;
        h = 3'd2;
        frame4("roi", 16'h0660, 1, 1, 0, 1'b1);
        check("roi_count", 64'(fc), 64'd2);

        x0 = 2'd0;
        y0 = 2'd0;
        w = 3'd4;
        h = 3'd4;
        dec = 2'd1;
        frame4("dec2", 16'h0505, 0, 0, 1, 1'b0);
        check("dec2_count", 64'(fc), 64'd3);

        dec = 2'd0;
        cyc(1'b1, 1'b1, 10'd1);
        cyc(1'b1, 1'b1, 10'd2);
        cyc(1'b1, 1'b0, 10'd0);
        check("len_first", 64'(lle), 64'd0);
        cyc(1'b1, 1'b1, 10'd3);
        cyc(1'b1, 1'b1, 10'd4);
        cyc(1'b1, 1'b1, 10'd5);
        check("len_pending", 64'(lle), 64'd0);
        cyc(1'b1, 1'b0, 10'd0);
        check("len_err", 64'(lle), 64'd1);
        cyc(1'b0, 1'b0, 10'd0);
        check("len_sticky", 64'(lle), 64'd1);

        cyc(1'b1, 1'b1, 10'd5);
        check("len_clr", 64'({lle, ovf}), 64'd0);
        cyc(1'b1, 1'b1, 10'd6);
        cyc(1'b1, 1'b1, 10'd7);
        cyc(1'b1, 1'b1, 10'd8);
        chk_pix("ovf_last", 1'b0, 10'd8, 2'd3, 2'd0);
        check("ovf_clear", 64'(ovf), 64'd0);
        cyc(1'b1, 1'b1, 10'd9);
        check("ovf_drop", 64'({pv, dout}), 64'({1'b0, 10'd8}));
        check("ovf_set", 64'(ovf), 64'd1);
        cyc(1'b1, 1'b0, 10'd0);
        cyc(1'b0, 1'b0, 10'd0);
        check("ovf_count", 64'({fc, ovf}), 64'({16'd5, 1'b1}));

        cyc(1'b1, 1'b1, 10'd40);
        chk_pix("rst_p40", 1'b1, 10'd40, 2'd0, 2'd0);
        cyc(1'b1, 1'b1, 10'd41);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        cyc(1'b1, 1'b1, 10'd42);
        cyc(1'b1, 1'b1, 10'd42);
        check_all_zero("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 10'd43);
            check("partial_drop", 64'(pv), 64'd0);
        end
        cyc(1'b0, 1'b0, 10'd0);
        check("partial_no_fend", 64'({fe, fc}), 64'd0);
        cyc(1'b1, 1'b1, 10'd50);
        chk_pix("recover", 1'b1, 10'd50, 2'd0, 2'd0);
        cyc(1'b1, 1'b0, 10'd0);
        cyc(1'b0, 1'b0, 10'd0);
        check("recover_count", 64'({fe, fc}), 64'({1'b1, 16'd1}));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/camera_window.md
CAMERA_WINDOW -- requirements
Module: camera_window

Interface
REQ-001 SHALL have parameter DATA_W, default 10, meaning pixel data width.
REQ-002 SHALL have parameter MAX_W, default 752, meaning max pixels per line; CW = clog2(MAX_W).
REQ-003 SHALL have parameter MAX_H, default 480, meaning max lines per frame; LW = clog2(MAX_H).
REQ-004 SHALL have port PIXCLK  in  1  sensor pixel clock, sole clock; all inputs sampled on its rising edge.
REQ-005 SHALL have port RESET_N  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports FRAME_VALID, LINE_VALID  in  1 each  sensor sync strobes.
REQ-007 SHALL have port DATA_IN  in  DATA_W  sensor pixel.
REQ-008 SHALL have port ENABLE  in  1  capture enable, sampled only at frame start.
REQ-009 SHALL have ports ROI_X0 in CW, ROI_Y0 in LW, ROI_W in CW+1, ROI_H in LW+1  window origin and size (size 1..MAX).
REQ-010 SHALL have port DECIM  in  2  decimation: 0=1x, 1=2x, 2=4x, 3 treated as 4x.
REQ-011 SHALL have port DATA_OUT  out  DATA_W  windowed pixel.
REQ-012 SHALL have ports CURRENT_COLUMN out CW, CURRENT_LINE out LW  output-pixel coordinates relative to window, post-decimation.
REQ-013 SHALL have ports PIXEL_VALID, FRAME_START, FRAME_END  out  1 each  single-cycle qualifiers.
REQ-014 SHALL have ports FRAME_COUNT out 16, LINE_LEN_ERR out 1, OVERFLOW_ERR out 1  status.

Function
REQ-015 SHALL implement FSM WAIT_IDLE -> ARMED when FRAME_VALID=0; ARMED -> ACTIVE when FRAME_VALID=1 and ENABLE=1; ACTIVE -> ARMED when FRAME_VALID=0.
REQ-016 SHALL ignore any frame already in progress at reset release (WAIT_IDLE discards all pixels).
REQ-017 SHALL latch ROI_*, DECIM on the ARMED->ACTIVE transition; changes mid-frame SHALL have no effect until the next frame.
REQ-018 SHALL accept a pixel in the same cycle FRAME_VALID rises if LINE_VALID=1 (first pixel of the frame).
REQ-019 SHALL keep absolute column counter (0 at each line start, +1 per LINE_VALID=1 cycle) and absolute line counter (+1 on each LINE_VALID falling edge in ACTIVE).
REQ-020 SHALL emit a pixel iff X0<=col<X0+W, Y0<=line<Y0+H, and (col-X0), (line-Y0) have their low DECIM bits zero.
REQ-021 SHALL present DATA_OUT, CURRENT_COLUMN=(col-X0)>>DECIM, CURRENT_LINE=(line-Y0)>>DECIM with PIXEL_VALID=1 exactly one cycle after sampling (latency 1).
REQ-022 SHALL hold DATA_OUT and coordinates stable when PIXEL_VALID=0.
REQ-023 SHALL pulse FRAME_START with the first emitted pixel of a frame; SHALL pulse FRAME_END one cycle after FRAME_VALID is sampled low in ACTIVE.
REQ-024 SHALL increment FRAME_COUNT (wrapping 0xFFFF->0) with each FRAME_END.
REQ-025 SHALL record the first line's length per frame; any later line of different length SHALL set LINE_LEN_ERR one cycle after that line ends.
REQ-026 SHALL saturate the column counter at MAX_W; pixels beyond SHALL be dropped and OVERFLOW_ERR set; line counter likewise saturates at MAX_H.
REQ-027 SHALL clear LINE_LEN_ERR and OVERFLOW_ERR on ARMED->ACTIVE; otherwise sticky.
REQ-028 SHALL treat a FRAME_VALID fall concurrent with LINE_VALID=1 as frame end; that pixel is dropped.

Reset
REQ-029 SHALL, on RESET_N=0, immediately enter WAIT_IDLE and drive all outputs and counters to 0, including mid-frame.
REQ-030 SHALL leave WAIT_IDLE only via REQ-015 after RESET_N returns high.

Structure
REQ-031 SHALL take FSM state enum and DECIM encodings from shared package camera_pkg.
REQ-032 SHALL place the FSM and raw counters in sub-module camera_frame_sync; windowing/decimation/output stage in camera_window.

Verification (MAX_W=4, MAX_H=4, DATA_W=10, 1x, full window unless stated)
REQ-033 SHALL test: reset release with FRAME_VALID=LINE_VALID=1 for 4 cycles -> no PIXEL_VALID until FRAME_VALID low then high.
REQ-034 SHALL test: 3 lines of 2 pixels 11,12/21,22/31,32 -> (0,0)11,(1,0)12,(0,1)21,(1,1)22,(0,2)31,(1,2)32 each 1 cycle late; FRAME_START with 11; FRAME_END once; FRAME_COUNT=1.
REQ-035 SHALL test: ROI X0=1,Y0=1,W=2,H=2, 4x4 frame -> only absolute (1..2,1..2) emitted, coordinates (0..1,0..1).
REQ-036 SHALL test: DECIM=1, 4x4 frame -> 4 pixels from absolute (0,0),(2,0),(0,2),(2,2) at (0,0),(1,0),(0,1),(1,1).
REQ-037 SHALL test: line lengths 2 then 3 -> LINE_LEN_ERR=1 after second line, 0 at next frame; a 5-pixel line -> 5th dropped, OVERFLOW_ERR=1.
REQ-038 SHALL test: RESET_N low mid-line -> outputs 0 same cycle; following partial frame ignored.
